alu_arbiter: RTL
================

# alu_arbiter

Shares the single combinational ALU between NREQ independent requesters (e.g. EX stage, address-gen unit, multi-cycle helper). Each requester presents operands and an opcode over a valid/ready handshake; the arbiter grants one request at a time, drives the ALU from registered operands and returns the registered result to the granted requester over a valid/ready response channel. It sits directly in front of the ALU instance and owns its inputs exclusively.

## Interface
- NREQ, 2, number of requesters, legal 2..4
- DW, 32, operand/result width
- OPW, 4, opcode width; codes from shared package
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  request present, per requester
- req_ready  out  NREQ  request accepted this cycle (one-hot or zero)
- req_a  in  NREQ*DW  operand A, requester i at [i*DW +: DW]
- req_b  in  NREQ*DW  operand B, same packing
- req_op  in  NREQ*OPW  opcode, same packing
- resp_valid  out  NREQ  result available for requester i (one-hot or zero)
- resp_ready  in  NREQ  requester i consumes result
- resp_c  out  DW  result, shared bus, meaningful only where resp_valid set
- alu_a, alu_b  out  DW  to ALU operand ports
- alu_op  out  OPW  to ALU opcode port
- alu_c  in  DW  from ALU result port

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state IDLE.
- IDLE: if any req_valid, grant winner g; req_ready[g]=1 for that cycle; latch a/b/op of g and g index; go EXEC. Else stay.
- EXEC: alu_a/alu_b/alu_op driven from latched registers (held stable whole cycle); capture alu_c into result register; go RESP.
- RESP: resp_valid[g]=1, resp_c=result register. On resp_ready[g] go IDLE; else hold, values stable.
- req_ready only asserted in IDLE; requesters must hold valid and payload stable until ready.
- resp_ready of non-granted requesters ignored.
- Opcodes not in package: forwarded unchanged; ALU returns 0; arbiter adds no checking.
- Single outstanding operation; throughput one op per 3 cycles minimum.

## Timing
- Reset values: req_ready=0, resp_valid=0, resp_c=0, alu_a=0, alu_b=0, alu_op=0, priority pointer=0, state IDLE.
- Accept at edge T (valid&ready) -> resp_valid high from T+2. Result available 2 cycles after accept.
- alu_* outputs are registers; no combinational path from req_* to alu_* or from alu_c to resp_c.
- req_ready depends combinationally on req_valid and state only; no path from resp_ready.
- Request withdrawn while not granted: legal, no effect.
- rst mid-operation: in-flight op discarded, no response produced, all outputs to reset values immediately.
- Simultaneous resp_ready in RESP and new req_valid: next accept occurs in the following IDLE cycle, not same cycle.

## Configuration
- ALU_ARB_RR_EN defined: round-robin; after grant to g, pointer = (g+1) mod NREQ; search starts at pointer. Pointer updates only on accept.
- Undefined: fixed priority, lowest index wins; pointer logic absent.

## Structure
- Package alu_pkg: opcode localparams ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_XOR=4, ALU_SLL=6, ALU_SRL=7, ALU_SRA=8; state enum typedef.
- One sub-module: alu_arb_pick (combinational winner select from valid vector + pointer, one-hot grant), reused by both configurations.

## Test plan
- Single request: req0 a=5,b=3,op=ADD accepted at T -> resp_valid[0] at T+2, resp_c=8; resp_ready held -> IDLE at T+3.
- Contention, RR build: req0 and req1 valid continuously, ops SUB 10-4 and XOR 0xF0^0x0F -> grants alternate 0,1,0; results 6 and 0xFF; fixed build: always 0.
- Backpressure: req1 SLL 1<<4 accepted, resp_ready[1]=0 for 5 cycles -> resp_valid[1] and resp_c=16 held stable, no new req_ready.
- Shift ops: SRA a=0x80000000 b=4 -> 0xF8000000; SRL same -> 0x08000000.
- Reset mid-EXEC: assert rst in EXEC -> all outputs 0 asynchronously, no response after release, next request served normally.
- Invalid opcode 5: accepted, resp_c=0 after 2 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU opcode codes and the arbiter state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;
  localparam logic [3:0] ALU_SRA = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_arb_pick.sv
// Combinational winner select: first valid requester at or after the pointer,
// wrapping modulo NREQ. Produces a one-hot grant and the winner index.
module alu_arb_pick #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [PW-1:0]   o_idx
);

  logic w_found;
  logic w_hit;
  int   v_k;

  // Rotating scan starting at the pointer; the first hit wins.
  always_comb begin
    o_gnt   = {NREQ{1'b0}};
    o_idx   = {PW{1'b0}};
    w_found = 1'b0;
    w_hit   = 1'b0;
    v_k     = 0;
    for (int i = 0; i < NREQ; i++) begin
      v_k        = (int'(i_ptr) + i) % NREQ;
      w_hit      = i_valid[v_k] && !w_found;
      o_gnt[v_k] = o_gnt[v_k] | w_hit;
      o_idx      = w_hit ? PW'(v_k) : o_idx;
      w_found    = w_found | w_hit;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NREQ requesters: IDLE/EXEC/RESP FSM.
// Optional macro ALU_ARB_RR_EN selects round-robin; default is fixed priority.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = 32,
  parameter int OPW  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*DW-1:0]  req_a,
  input  logic [NREQ*DW-1:0]  req_b,
  input  logic [NREQ*OPW-1:0] req_op,
  output logic [NREQ-1:0]   resp_valid,
  input  logic [NREQ-1:0]   resp_ready,
  output logic [DW-1:0]     resp_c,
  output logic [DW-1:0]     alu_a,
  output logic [DW-1:0]     alu_b,
  output logic [OPW-1:0]    alu_op,
  input  logic [DW-1:0]     alu_c
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e      r_state;
  logic [PW-1:0]   r_gidx;
  logic [DW-1:0]   r_a;
  logic [DW-1:0]   r_b;
  logic [OPW-1:0]  r_op;
  logic [DW-1:0]   r_result;
  logic [NREQ-1:0] r_resp_valid;
  logic [NREQ-1:0] w_gnt;
  logic [PW-1:0]   w_gnt_idx;
  logic [PW-1:0]   w_ptr;

`ifdef ALU_ARB_RR_EN
  logic [PW-1:0]   r_ptr;
  assign w_ptr = r_ptr;
`else
  assign w_ptr = {PW{1'b0}};
`endif

  alu_arb_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .i_valid (req_valid),
    .i_ptr   (w_ptr),
    .o_gnt   (w_gnt),
    .o_idx   (w_gnt_idx)
  );

  // Gated by rst so nothing is accepted while reset holds the FSM in IDLE.
  assign req_ready  = (r_state == ST_IDLE && !rst) ? w_gnt : {NREQ{1'b0}};
  assign resp_valid = r_resp_valid;
  assign resp_c     = r_result;
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_op     = r_op;

  // Arbitration FSM: latch on accept, capture ALU result, hold until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_gidx       <= {PW{1'b0}};
      r_a          <= {DW{1'b0}};
      r_b          <= {DW{1'b0}};
      r_op         <= {OPW{1'b0}};
      r_result     <= {DW{1'b0}};
      r_resp_valid <= {NREQ{1'b0}};
`ifdef ALU_ARB_RR_EN
      r_ptr        <= {PW{1'b0}};
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req_valid) begin
            r_a     <= req_a[int'(w_gnt_idx)*DW +: DW];
            r_b     <= req_b[int'(w_gnt_idx)*DW +: DW];
            r_op    <= req_op[int'(w_gnt_idx)*OPW +: OPW];
            r_gidx  <= w_gnt_idx;
            r_state <= ST_EXEC;
`ifdef ALU_ARB_RR_EN
            r_ptr   <= (w_gnt_idx == PW'(NREQ-1)) ? {PW{1'b0}} : w_gnt_idx + PW'(1);
`endif
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          r_result     <= alu_c;
          r_resp_valid <= {{(NREQ-1){1'b0}}, 1'b1} << r_gidx;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready[r_gidx]) begin
            r_resp_valid <= {NREQ{1'b0}};
            r_state      <= ST_IDLE;
          end else begin
            r_state      <= ST_RESP;
          end
        end
        default: begin
          r_resp_valid <= {NREQ{1'b0}};
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
